// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state type and counter-width helper for the bit-serial adder
package serial_adder_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t;
   function automatic int sa_cnt_w(input int width);
      return ($clog2(width) < 1) ? 1 : $clog2(width);
   endfunction
endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: operand and result valid/ready handshakes of the bit-serial adder
interface serial_adder_if #(parameter int WIDTH = 8) ();
   logic             in_valid, in_ready, cin;
   logic             out_valid, out_ready, cout, busy;
   logic [WIDTH-1:0] a, b, sum;
   modport master (output in_valid, a, b, cin, out_ready,
                   input  in_ready, out_valid, sum, cout, busy);
   modport slave  (input  in_valid, a, b, cin, out_ready,
                   output in_ready, out_valid, sum, cout, busy);
endinterface

// File: rtl/serial_adder_full_adder.sv
// full_adder: 1-bit full adder cell
module full_adder (
   input  logic x,
   input  logic y,
   input  logic cin,
   output logic s,
   output logic carry
);
   assign s     = x ^ y ^ cin;
   assign carry = (x & y) | (cin & (x ^ y));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial WIDTH-bit adder built around one full_adder cell
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic           clk,
   input logic           rst_n,
   serial_adder_if.slave bus
);
   localparam int CW = sa_cnt_w(WIDTH);
   if (WIDTH < 1) begin : g_chk
      $fatal(1, "serial_adder: WIDTH must be >= 1");
   end
   sa_state_t        state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
   logic             carry_q, carry_d, cout_q, cout_d, fa_s, fa_c;
   full_adder u_fa (
      .x(a_q[0]), .y(b_q[0]), .cin(carry_q), .s(fa_s), .carry(fa_c)
   );
   // sum/cout are separate output flops so they hold steady while acc_q shifts
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      unique case (state_q)
         IDLE: if (bus.in_valid) begin
            a_d     = bus.a;
            b_d     = bus.b;
            carry_d = bus.cin;
            cnt_d   = '0;
            state_d = RUN;
         end
         RUN: begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            acc_d   = (acc_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
            carry_d = fa_c;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = DONE;
               sum_d   = acc_d;
               cout_d  = fa_c;
            end
         end
         DONE: state_d = bus.out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end
   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: vector table, scoreboard and corner sequences for WIDTH=8 and WIDTH=1
module tb_serial_adder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   serial_adder_if #(.WIDTH(8)) i8 ();
   serial_adder_if #(.WIDTH(1)) i1 ();
   serial_adder #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(i8));
   serial_adder #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1));

   typedef struct {
      logic [7:0] a, b;
      logic       cin;
      logic [7:0] sum;
      logic       cout;
   } vec_t;
   vec_t vecs[6];
   int checks = 0;
   int failures = 0;
   logic [8:0] sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic accept(input bit w1, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic [8:0] exp);
      int n;
      @(negedge clk);
      if (w1) begin
         i1.in_valid = 1'b1; i1.a = a[0]; i1.b = b[0]; i1.cin = cin;
      end else begin
         i8.in_valid = 1'b1; i8.a = a; i8.b = b; i8.cin = cin;
      end
      sb.push_back(exp);
      for (n = 0; n < 50 && !(w1 ? i1.in_ready : i8.in_ready); n++) @(negedge clk);
      check("accept_ready", 32'(w1 ? i1.in_ready : i8.in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      i1.in_valid = 1'b0;
      i8.in_valid = 1'b0;
   endtask

   task automatic wait_valid(input bit w1, inout int n);
      while (n < 100 && !(w1 ? i1.out_valid : i8.out_valid)) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
   endtask

   task automatic collect(input bit w1, input int lat, input string name);
      int n = 0;
      logic [8:0] exp, act;
      wait_valid(w1, n);
      check({name, "_latency"}, 32'(n), 32'(lat));
      exp = (sb.size() > 0) ? sb.pop_front() : 9'h1xx;
      act = w1 ? {7'b0, i1.cout, i1.sum} : {i8.cout, i8.sum};
      check(name, 32'(act), 32'(exp));
      i1.out_ready = w1;
      i8.out_ready = !w1;
      @(posedge clk);
      @(negedge clk);
      i1.out_ready = 1'b0;
      i8.out_ready = 1'b0;
      check({name, "_in_ready_after"}, 32'(w1 ? i1.in_ready : i8.in_ready), 32'd1);
      check({name, "_out_valid_after"}, 32'(w1 ? i1.out_valid : i8.out_valid), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [8:0] exp;
      logic [7:0] ra, rb;
      logic rc;
      logic [2:0] v;
      {i8.in_valid, i8.a, i8.b, i8.cin, i8.out_ready} = '0;
      {i1.in_valid, i1.a, i1.b, i1.cin, i1.out_ready} = '0;
      vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vecs[2] = '{8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1};
      vecs[3] = '{8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0};
      vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
      repeat (2) @(negedge clk);
      check("rst_in_ready", 32'(i8.in_ready), 32'd1);
      check("rst_out_valid", 32'(i8.out_valid), 32'd0);
      check("rst_busy", 32'(i8.busy), 32'd0);
      check("rst_sum", 32'(i8.sum), 32'd0);
      check("rst_cout", 32'(i8.cout), 32'd0);
      check("rst_w1_in_ready", 32'(i1.in_ready), 32'd1);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         accept(1'b0, vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].cout, vecs[i].sum});
         check("busy_in_run", 32'(i8.busy), 32'd1);
         collect(1'b0, 8, "vec");
      end

      // backpressure, with in_valid/a wiggled during RUN
      accept(1'b0, 8'h12, 8'h34, 1'b1, 9'h047);
      @(negedge clk);
      i8.in_valid = 1'b1; i8.a = 8'hFF; i8.cin = 1'b0;
      @(negedge clk);
      i8.in_valid = 1'b0; i8.a = 8'h00;
      n = 2;
      wait_valid(1'b0, n);
      check("bp_latency", 32'(n), 32'd8);
      exp = sb.pop_front();
      for (int k = 0; k < 5; k++) begin
         check("bp_sum", 32'(i8.sum), 32'(exp[7:0]));
         check("bp_cout", 32'(i8.cout), 32'(exp[8]));
         check("bp_out_valid", 32'(i8.out_valid), 32'd1);
         @(negedge clk);
      end
      i8.out_ready = 1'b1;
      i8.in_valid = 1'b1; i8.a = 8'h01; i8.b = 8'h01;
      @(posedge clk);
      @(negedge clk);
      i8.out_ready = 1'b0;
      i8.in_valid = 1'b0;
      check("bp_in_ready_after", 32'(i8.in_ready), 32'd1);
      check("bp_no_same_cycle_accept", 32'(i8.busy), 32'd0);
      check("bp_sum_held", 32'(i8.sum), 32'h47);

      // reset in the middle of RUN
      accept(1'b0, 8'h77, 8'h11, 1'b0, 9'h088);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 32'(i8.out_valid), 32'd0);
      check("mid_rst_in_ready", 32'(i8.in_ready), 32'd1);
      check("mid_rst_sum", 32'(i8.sum), 32'd0);
      check("mid_rst_busy", 32'(i8.busy), 32'd0);
      void'(sb.pop_back());
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      check("mid_rst_no_valid", 32'(i8.out_valid), 32'd0);
      accept(1'b0, 8'h10, 8'h20, 1'b0, 9'h030);
      collect(1'b0, 8, "post_rst");

      for (int c = 0; c < 8; c++) begin
         v = c[2:0];
         accept(1'b1, {7'b0, v[2]}, {7'b0, v[1]}, v[0],
                9'(v[2]) + 9'(v[1]) + 9'(v[0]));
         collect(1'b1, 1, "w1");
      end

      for (int k = 0; k < 200; k++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = 1'($urandom);
         accept(1'b0, ra, rb, rc, 9'(ra) + 9'(rb) + 9'(rc));
         collect(1'b0, 8, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
